// File: rtl/can_destuff_checker.sv
// can_destuff_checker
//   Removes stuff bits from the sampled CAN RX stream and checks the
//   stuffing rules.
//   - Dynamic stuffing (CAN classic/FD): after STUFF_LEN identical bits,
//     the next bit must be a complement stuff bit.
//   - Fixed stuffing (FD CRC field): a complement stuff bit is expected
//     at region entry and then after every FIX_LEN data bits.
//   Clocked on the sample-point strobe. Every output is registered and
//   describes the bit that was sampled on the same SP edge.
//
// Parameters
//   STUFF_LEN  identical consecutive bits that force a dynamic stuff bit (>= 2)
//   FIX_LEN    data bits between fixed stuff bits (>= 1)
//   CNT_W      width of ERR_CNT
//
// Ports
//   SP        in   clock; one rising edge per sampled bit
//   reset     in   asynchronous reset, active low
//   RX        in   sampled bus bit
//   F_STF     in   stuff-region enable, active low (1 = outside the region)
//   FIX_STF   in   1 = fixed-stuff region; only meaningful while F_STF = 0
//   RX_OUT    out  destuffed data bit (holds its value across stuff bits)
//   RX_VALID  out  RX_OUT carries a data bit for this SP
//   STF_BIT   out  the bit sampled on this SP was a correct stuff bit and was dropped
//   STF_ERR   out  stuff-error pulse, active low, one SP long
//   ERR_CNT   out  number of stuff errors since reset; saturates at all ones
module can_destuff_checker #(
  parameter int unsigned STUFF_LEN = 5,
  parameter int unsigned FIX_LEN   = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             SP,
  input  logic             reset,
  input  logic             RX,
  input  logic             F_STF,
  input  logic             FIX_STF,
  output logic             RX_OUT,
  output logic             RX_VALID,
  output logic             STF_BIT,
  output logic             STF_ERR,
  output logic [CNT_W-1:0] ERR_CNT
);

  localparam int unsigned RL_W = $clog2(STUFF_LEN + 1);
  localparam int unsigned FC_W = $clog2(FIX_LEN + 1);
  localparam logic [RL_W-1:0] RUN_MAX = RL_W'(STUFF_LEN);
  localparam logic [FC_W-1:0] FIX_MAX = FC_W'(FIX_LEN);

  typedef enum logic [1:0] {
    IDLE,
    DYN,
    FIX,
    HALT
  } state_t;

  state_t          state, state_n;
  logic            run_bit, run_bit_n;
  logic [RL_W-1:0] run_len, run_len_n;
  logic [FC_W-1:0] fix_cnt, fix_cnt_n;
  logic            rx_out_n;
  logic            rx_valid_n;
  logic            stf_bit_n;
  logic            stf_err_n;
  logic [CNT_W-1:0] err_cnt_n;
  logic            stuff_err;

  always_ff @(posedge SP or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      run_bit  <= 1'b0;
      run_len  <= '0;
      fix_cnt  <= '0;
      RX_OUT   <= 1'b1;
      RX_VALID <= 1'b0;
      STF_BIT  <= 1'b0;
      STF_ERR  <= 1'b1;
      ERR_CNT  <= '0;
    end else begin
      state    <= state_n;
      run_bit  <= run_bit_n;
      run_len  <= run_len_n;
      fix_cnt  <= fix_cnt_n;
      RX_OUT   <= rx_out_n;
      RX_VALID <= rx_valid_n;
      STF_BIT  <= stf_bit_n;
      STF_ERR  <= stf_err_n;
      ERR_CNT  <= err_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    run_bit_n  = run_bit;
    run_len_n  = run_len;
    fix_cnt_n  = fix_cnt;
    rx_out_n   = RX_OUT;
    rx_valid_n = 1'b0;
    stf_bit_n  = 1'b0;
    stf_err_n  = 1'b1;
    err_cnt_n  = ERR_CNT;
    stuff_err  = 1'b0;

    if (F_STF) begin
      // Leaving the stuff region overrides everything, including a pending error.
      state_n   = IDLE;
      run_len_n = '0;
      fix_cnt_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n    = DYN;
          rx_out_n   = RX;
          rx_valid_n = 1'b1;
          run_bit_n  = RX;
          run_len_n  = RL_W'(1);
        end

        DYN: begin
          if (FIX_STF) begin
            // Leading fixed stuff bit: compared with the last data bit,
            // the dynamic run is ignored here.
            if (RX == ~RX_OUT) begin
              state_n   = FIX;
              stf_bit_n = 1'b1;
              fix_cnt_n = '0;
            end else begin
              stuff_err = 1'b1;
            end
          end else if (run_len < RUN_MAX) begin
            rx_out_n   = RX;
            rx_valid_n = 1'b1;
            if (RX == run_bit) begin
              run_len_n = run_len + RL_W'(1);
            end else begin
              run_bit_n = RX;
              run_len_n = RL_W'(1);
            end
          end else begin
            // The stuff bit itself opens the next run.
            if (RX != run_bit) begin
              stf_bit_n = 1'b1;
              run_bit_n = RX;
              run_len_n = RL_W'(1);
            end else begin
              stuff_err = 1'b1;
            end
          end
        end

        FIX: begin
          if (!FIX_STF) begin
            // Fixed region may only be left through F_STF; stop silently.
            state_n = HALT;
          end else if (fix_cnt < FIX_MAX) begin
            rx_out_n   = RX;
            rx_valid_n = 1'b1;
            fix_cnt_n  = fix_cnt + FC_W'(1);
          end else if (RX == ~RX_OUT) begin
            stf_bit_n = 1'b1;
            fix_cnt_n = '0;
          end else begin
            stuff_err = 1'b1;
          end
        end

        HALT: begin
          state_n = HALT;
        end

        default: begin
          state_n = HALT;
        end
      endcase

      if (stuff_err) begin
        state_n    = HALT;
        rx_valid_n = 1'b0;
        stf_bit_n  = 1'b0;
        stf_err_n  = 1'b0;
        if (ERR_CNT != '1) begin
          err_cnt_n = ERR_CNT + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_can_destuff_checker.sv
// tb_can_destuff_checker
//   Directed, table-driven bench for can_destuff_checker with default
//   parameters (STUFF_LEN=5, FIX_LEN=4, CNT_W=8). Each table row gives the
//   inputs for one SP edge and the expected registered outputs after it.
module tb_can_destuff_checker;

  logic       sp;
  logic       reset;
  logic       rx;
  logic       f_stf;
  logic       fix_stf;
  logic       rx_out;
  logic       rx_valid;
  logic       stf_bit;
  logic       stf_err;
  logic [7:0] err_cnt;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  typedef struct {
    logic       f;
    logic       fx;
    logic       r;
    logic       e_out;
    logic       e_valid;
    logic       e_stf;
    logic       e_err;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  can_destuff_checker #(
    .STUFF_LEN(5),
    .FIX_LEN  (4),
    .CNT_W    (8)
  ) dut (
    .SP      (sp),
    .reset   (reset),
    .RX      (rx),
    .F_STF   (f_stf),
    .FIX_STF (fix_stf),
    .RX_OUT  (rx_out),
    .RX_VALID(rx_valid),
    .STF_BIT (stf_bit),
    .STF_ERR (stf_err),
    .ERR_CNT (err_cnt)
  );

  initial sp = 1'b0;
  always #5 sp = ~sp;

  function automatic logic [11:0] outs();
    return {rx_out, rx_valid, stf_bit, stf_err, err_cnt};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got out/valid/stf/err=%b%b%b%b cnt=%0d, expected %b%b%b%b cnt=%0d",
               name, act[11], act[10], act[9], act[8], act[7:0],
               exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic apply(input logic f, input logic fx, input logic r);
    f_stf   = f;
    fix_stf = fx;
    rx      = r;
    @(posedge sp);
    #1;
  endtask

  task automatic add(input logic f, input logic fx, input logic r, input logic o,
                     input logic va, input logic s, input logic e, input logic [7:0] c);
    vec_t v;
    v.f = f; v.fx = fx; v.r = r;
    v.e_out = o; v.e_valid = va; v.e_stf = s; v.e_err = e; v.e_cnt = c;
    vecs.push_back(v);
  endtask

  initial begin
    //  f  fx rx  out val stf err cnt
    add(1, 0, 1,  1,  0,  0,  1,  0);           // outside region
    // T1: five 0s then a 1 stuff bit, then a data 1
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 1,  0,  0,  1,  1,  0);
    add(0, 0, 1,  1,  1,  0,  1,  0);           // run_len=2
    // T3: stuff bit started the run; three more 1s complete it, next must be 0
    for (int i = 0; i < 3; i++) add(0, 0, 1, 1, 1, 0, 1, 0);
    add(0, 0, 0,  1,  0,  1,  1,  0);
    // T7: four more 0s, then F_STF=1 on the would-be error edge
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, 0, 1, 0);
    add(1, 0, 0,  0,  0,  0,  1,  0);
    // T2: six 1s -> error on the 6th, then HALT stays silent
    for (int i = 0; i < 5; i++) add(0, 0, 1, 1, 1, 0, 1, 0);
    add(0, 0, 1,  1,  0,  0,  0,  1);
    add(0, 0, 1,  1,  0,  0,  1,  1);
    add(0, 0, 0,  1,  0,  0,  1,  1);
    add(1, 0, 1,  1,  0,  0,  1,  1);
    // T4: last data bit 0, leading fixed stuff 1, d=1,0,0,1, stuff 0,
    //     d=0,1,1,0, then stuff equal to d4 -> error
    add(0, 0, 1,  1,  1,  0,  1,  1);
    add(0, 0, 0,  0,  1,  0,  1,  1);
    add(0, 1, 1,  0,  0,  1,  1,  1);
    add(0, 1, 1,  1,  1,  0,  1,  1);
    add(0, 1, 0,  0,  1,  0,  1,  1);
    add(0, 1, 0,  0,  1,  0,  1,  1);
    add(0, 1, 1,  1,  1,  0,  1,  1);
    add(0, 1, 0,  1,  0,  1,  1,  1);
    add(0, 1, 0,  0,  1,  0,  1,  1);
    add(0, 1, 1,  1,  1,  0,  1,  1);
    add(0, 1, 1,  1,  1,  0,  1,  1);
    add(0, 1, 0,  0,  1,  0,  1,  1);
    add(0, 1, 0,  0,  0,  0,  0,  2);
    add(0, 1, 1,  0,  0,  0,  1,  2);
    add(1, 0, 1,  0,  0,  0,  1,  2);
    // FIX_STF dropped while inside the region -> HALT, no pulse
    add(0, 0, 1,  1,  1,  0,  1,  2);
    add(0, 1, 0,  1,  0,  1,  1,  2);
    add(0, 0, 1,  1,  0,  0,  1,  2);
    add(0, 0, 0,  1,  0,  0,  1,  2);
    add(1, 0, 0,  1,  0,  0,  1,  2);
    // leading fixed stuff bit equal to the last data bit -> error
    add(0, 0, 0,  0,  1,  0,  1,  2);
    add(0, 1, 0,  0,  0,  0,  0,  3);
    add(0, 1, 1,  0,  0,  0,  1,  3);
    add(1, 0, 1,  0,  0,  0,  1,  3);

    reset   = 1'b0;
    f_stf   = 1'b1;
    fix_stf = 1'b0;
    rx      = 1'b1;
    #12;
    check("reset_state", outs(), {1'b1, 1'b0, 1'b0, 1'b1, 8'd0});
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].f, vecs[i].fx, vecs[i].r);
      check($sformatf("vec[%0d]", i), outs(),
            {vecs[i].e_out, vecs[i].e_valid, vecs[i].e_stf, vecs[i].e_err, vecs[i].e_cnt});
    end

    // T6: asynchronous reset in the middle of a fixed-stuff region
    apply(0, 0, 0);
    check("t6_data", outs(), {1'b0, 1'b1, 1'b0, 1'b1, 8'd3});
    apply(0, 1, 1);
    check("t6_lead_stuff", outs(), {1'b0, 1'b0, 1'b1, 1'b1, 8'd3});
    apply(0, 1, 0);
    #2 reset = 1'b0;
    #1;
    check("t6_async_reset", outs(), {1'b1, 1'b0, 1'b0, 1'b1, 8'd0});
    #2 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 1);
      check($sformatf("t6_run[%0d]", i), outs(), {1'b1, 1'b1, 1'b0, 1'b1, 8'd0});
    end
    apply(0, 0, 0);
    check("t6_stuff_after_5", outs(), {1'b1, 1'b0, 1'b1, 1'b1, 8'd0});

    // T5: counter saturation; every error still pulses STF_ERR
    for (int k = 1; k <= 256; k++) begin
      apply(1, 0, 1);
      for (int i = 0; i < 5; i++) apply(0, 0, 1);
      apply(0, 0, 1);
      check($sformatf("t5_err[%0d]", k), outs(),
            {1'b1, 1'b0, 1'b0, 1'b0, (k > 255) ? 8'd255 : 8'(k)});
    end
    apply(1, 0, 1);
    check("t5_idle_after_sat", outs(), {1'b1, 1'b0, 1'b0, 1'b1, 8'd255});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
